mac_result_collector: RTL

Consumer end of the MAC_ACC datapath: receives the accumulator output `p` beat-by-beat and turns it into per-neuron results.
- Counts chunk beats per neuron and captures the final accumulated sum of each neuron.
- Scales and saturates that sum to 8 bits, optionally applies ReLU, and stores it in a small neuron register file.
- Tracks the running argmax and reports the winning class index for the image.
- Sits between MAC_ACC and the next layer or readout logic.

---
 rtl/mac_result_collector_if.sv | 10 +
 rtl/mac_result_collector.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mac_result_collector_if.sv
// MAC beat stream from MAC_ACC into mac_result_collector.
interface mac_result_collector_if #(
    parameter int P_W = 22
);
    logic           in_valid;
    logic [P_W-1:0] in_p;

    modport master (output in_valid, in_p);
    modport slave  (input  in_valid, in_p);
endinterface

// File: rtl/mac_result_collector.sv
// Collects MAC_ACC beats into per-neuron 8-bit results, a small register file and a running argmax.
// Optional feature macro: MAC_COLLECT_RELU_EN (clamp negative results to 0 before storing).
module mac_result_collector #(
    parameter int P_W     = 22,
    parameter int OUT_W   = 8,
    parameter int NEURONS = 10,
    parameter int CHUNKS  = 4,
    parameter int SHIFT   = 4,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    mac_result_collector_if.slave mac,
    input  logic                 ack,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [OUT_W-1:0]     rd_data,
    output logic                 busy,
    output logic                 neuron_we,
    output logic [IDX_W-1:0]     neuron_idx,
    output logic [OUT_W-1:0]     neuron_val,
    output logic                 done,
    output logic [IDX_W-1:0]     class_idx,
    output logic [OUT_W-1:0]     class_score,
    output logic                 overrun
);
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK  = CW'(CHUNKS - 1);
    localparam logic [IDX_W-1:0] LAST_NEURON = IDX_W'(NEURONS - 1);
    localparam logic signed [P_W-1:0] SAT_HI = P_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [P_W-1:0] SAT_LO = -SAT_HI - P_W'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        chunk_cnt;
    logic [IDX_W-1:0]     neuron_cnt;
    logic                 best_valid;
    logic [OUT_W-1:0]     mem [NEURONS];

    logic signed [P_W-1:0]   p_s;
    logic signed [P_W-1:0]   shifted;
    logic signed [OUT_W-1:0] sat_val;
    logic signed [OUT_W-1:0] res_val;

    assign p_s = mac.in_p;

    always_comb begin
        shifted = p_s >>> SHIFT;
        if (shifted > SAT_HI)
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        else if (shifted < SAT_LO)
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else
            sat_val = shifted[OUT_W-1:0];
`ifdef MAC_COLLECT_RELU_EN
        res_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            chunk_cnt   <= '0;
            neuron_cnt  <= '0;
            best_valid  <= 1'b0;
            mem         <= '{default: '0};
            rd_data     <= '0;
            busy        <= 1'b0;
            neuron_we   <= 1'b0;
            neuron_idx  <= '0;
            neuron_val  <= '0;
            done        <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            overrun     <= 1'b0;
        end else begin
            neuron_we <= 1'b0;
            // Out-of-range addresses read as zero; a same-cycle write is seen next cycle.
            rd_data   <= (rd_addr < IDX_W'(NEURONS)) ? mem[rd_addr] : '0;

            if (start) begin
                // start restarts from any state; the register file is left intact.
                state      <= COLLECT;
                busy       <= 1'b1;
                done       <= 1'b0;
                chunk_cnt  <= '0;
                neuron_cnt <= '0;
                best_valid <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (mac.in_valid) begin
                            if (chunk_cnt == LAST_CHUNK) begin
                                chunk_cnt       <= '0;
                                mem[neuron_cnt] <= res_val;
                                neuron_we       <= 1'b1;
                                neuron_idx      <= neuron_cnt;
                                neuron_val      <= res_val;
                                if (!best_valid || res_val > $signed(class_score)) begin
                                    class_idx   <= neuron_cnt;
                                    class_score <= res_val;
                                end
                                best_valid <= 1'b1;
                                if (neuron_cnt == LAST_NEURON) begin
                                    state      <= HOLD;
                                    busy       <= 1'b0;
                                    done       <= 1'b1;
                                    neuron_cnt <= '0;
                                end else begin
                                    neuron_cnt <= neuron_cnt + 1'b1;
                                end
                            end else begin
                                chunk_cnt <= chunk_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (mac.in_valid)
                            overrun <= 1'b1;
                        if (ack) begin
                            state <= IDLE;
                            done  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
